// File: rtl/lsu_ctrl_pkg.sv
// Shared types and constants for the load/store unit: memory opcodes,
// bus/data widths, FSM state encoding and small opcode classifiers.
package lsu_ctrl_pkg;

  localparam int CPU_WIDTH    = 32;
  localparam int MEM_OP_WIDTH = 4;

  localparam logic [MEM_OP_WIDTH-1:0] MEM_NO  = 4'd0;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LB  = 4'd1;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LH  = 4'd2;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LW  = 4'd3;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LBU = 4'd4;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_LHU = 4'd5;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_SB  = 4'd6;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_SH  = 4'd7;
  localparam logic [MEM_OP_WIDTH-1:0] MEM_SW  = 4'd8;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

  function automatic logic op_is_load(input logic [MEM_OP_WIDTH-1:0] op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic op_is_store(input logic [MEM_OP_WIDTH-1:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Unknown encodings are treated like MEM_NO and never start a transaction.
  function automatic logic op_is_mem(input logic [MEM_OP_WIDTH-1:0] op);
    return op_is_load(op) || op_is_store(op);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational store-data lane replication, byte-enable generation and
// misalignment detection for one memory op.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [MEM_OP_WIDTH-1:0] op,
  input  logic [1:0]              addr_lo,
  input  logic [CPU_WIDTH-1:0]    wdata,
  output logic [3:0]              be,
  output logic [CPU_WIDTH-1:0]    wdata_aligned,
  output logic                    we,
  output logic                    misalign
);

  // Derive lane enables, replicated store data and alignment from op size
  always_comb begin
    be            = 4'b0000;
    wdata_aligned = '0;
    misalign      = 1'b0;
    we            = op_is_store(op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: begin
        be = 4'b0001 << addr_lo;
      end
      MEM_LH, MEM_LHU, MEM_SH: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      MEM_LW, MEM_SW: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      default: begin
        be = 4'b0000;
      end
    endcase
    case (op)
      MEM_SB:  wdata_aligned = {4{wdata[7:0]}};
      MEM_SH:  wdata_aligned = {2{wdata[15:0]}};
      MEM_SW:  wdata_aligned = wdata;
      default: wdata_aligned = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: accepts one memory op at a time from execute, runs the
// req/gnt/rvalid data-bus handshake, stalls the core while busy, aborts on
// bus timeout and holds the last completed access for the writeback mux.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    lsu_vld,
  input  logic [MEM_OP_WIDTH-1:0] lsu_op,
  input  logic [CPU_WIDTH-1:0]    lsu_addr,
  input  logic [CPU_WIDTH-1:0]    lsu_wdata,
  output logic                    lsu_stall,
  output logic                    lsu_done,
  output logic                    lsu_misalign,
  output logic                    lsu_err,
  output logic [MEM_OP_WIDTH-1:0] wb_mem_op,
  output logic [CPU_WIDTH-1:0]    wb_mem_addr,
  output logic [CPU_WIDTH-1:0]    wb_mem_rdata,
  output logic                    dbus_req,
  output logic                    dbus_we,
  output logic [3:0]              dbus_be,
  output logic [CPU_WIDTH-1:0]    dbus_addr,
  output logic [CPU_WIDTH-1:0]    dbus_wdata,
  input  logic                    dbus_gnt,
  input  logic                    dbus_rvalid,
  input  logic [CPU_WIDTH-1:0]    dbus_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  lsu_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [MEM_OP_WIDTH-1:0] op_q, op_d;
  logic [CPU_WIDTH-1:0] addr_q, addr_d;
  logic [CPU_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0] be_q, be_d;
  logic we_q, we_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic mis_q, mis_d;
  logic [MEM_OP_WIDTH-1:0] wb_op_q, wb_op_d;
  logic [CPU_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [CPU_WIDTH-1:0] wb_rdata_q, wb_rdata_d;

  logic [3:0] al_be;
  logic [CPU_WIDTH-1:0] al_wdata;
  logic al_we, al_mis;
  logic present, accept, reject, timeout;

  lsu_align u_align (
    .op            (lsu_op),
    .addr_lo       (lsu_addr[1:0]),
    .wdata         (lsu_wdata),
    .be            (al_be),
    .wdata_aligned (al_wdata),
    .we            (al_we),
    .misalign      (al_mis)
  );

  // Qualify the incoming op; the completion/abort cycle still sees the old op on lsu_vld, so it is masked
  always_comb begin
    present = (state_q == LSU_IDLE) && lsu_vld && op_is_mem(lsu_op) && !done_q && !err_q;
    accept  = present && !al_mis;
    reject  = present && al_mis;
    timeout = (cnt_q == TO_LAST);
  end

  assign lsu_stall    = (state_q != LSU_IDLE) || accept;
  assign lsu_done     = done_q;
  assign lsu_err      = err_q;
  assign lsu_misalign = mis_q;
  assign wb_mem_op    = wb_op_q;
  assign wb_mem_addr  = wb_addr_q;
  assign wb_mem_rdata = wb_rdata_q;
  assign dbus_req     = (state_q == LSU_REQ);
  assign dbus_we      = dbus_req && we_q;
  assign dbus_be      = dbus_req ? be_q : 4'b0000;
  assign dbus_addr    = dbus_req ? {addr_q[CPU_WIDTH-1:2], 2'b00} : '0;
  assign dbus_wdata   = dbus_req ? wdata_q : '0;

  // Next-state, timeout counter, pulse and writeback-hold logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    mis_d      = 1'b0;
    wb_op_d    = wb_op_q;
    wb_addr_d  = wb_addr_q;
    wb_rdata_d = wb_rdata_q;
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          state_d = LSU_REQ;
          cnt_d   = 8'd0;
          op_d    = lsu_op;
          addr_d  = lsu_addr;
          wdata_d = al_wdata;
          be_d    = al_be;
          we_d    = al_we;
        end else if (reject) begin
          mis_d = 1'b1;
        end
      end
      LSU_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (dbus_gnt) begin
          state_d = LSU_RESP;
        end else if (timeout) begin
          state_d = LSU_IDLE;
          err_d   = 1'b1;
        end
      end
      LSU_RESP: begin
        cnt_d = cnt_q + 8'd1;
        if (dbus_rvalid) begin
          state_d = LSU_IDLE;
          done_d  = 1'b1;
          if (op_is_load(op_q)) begin
            wb_op_d    = op_q;
            wb_addr_d  = addr_q;
            wb_rdata_d = dbus_rdata;
          end else begin
            wb_op_d = MEM_NO;
          end
        end else if (timeout) begin
          state_d = LSU_IDLE;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LSU_IDLE;
      cnt_q      <= 8'd0;
      op_q       <= MEM_NO;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'b0000;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mis_q      <= 1'b0;
      wb_op_q    <= MEM_NO;
      wb_addr_q  <= '0;
      wb_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mis_q      <= mis_d;
      wb_op_q    <= wb_op_d;
      wb_addr_q  <= wb_addr_d;
      wb_rdata_q <= wb_rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized ops
// checked against a transaction-level model of sizes, lanes and latency.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  localparam int TO = 8;

  logic        clk, rst_n, lsu_vld;
  logic [3:0]  lsu_op;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_stall, lsu_done, lsu_misalign, lsu_err;
  logic [3:0]  wb_mem_op;
  logic [31:0] wb_mem_addr, wb_mem_rdata;
  logic        dbus_req, dbus_we;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_addr, dbus_wdata;
  logic        dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_rdata;

  int total = 0;
  int bad = 0;

  logic [3:0]  exp_op;
  logic [31:0] exp_addr, exp_rdata;

  int          obs_pre, obs_stall_pre, obs_stall_post, obs_done, obs_err, obs_mis, obs_req;
  bit          obs_unstable;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata;
  logic        obs_we;

  lsu_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .lsu_vld(lsu_vld), .lsu_op(lsu_op),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_stall(lsu_stall),
    .lsu_done(lsu_done), .lsu_misalign(lsu_misalign), .lsu_err(lsu_err),
    .wb_mem_op(wb_mem_op), .wb_mem_addr(wb_mem_addr), .wb_mem_rdata(wb_mem_rdata),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [3:0] op);
    if (op == MEM_LB || op == MEM_LBU || op == MEM_SB) return 1;
    if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return 2;
    if (op == MEM_LW || op == MEM_SW) return 4;
    return 0;
  endfunction

  function automatic bit m_store(input logic [3:0] op);
    return op == MEM_SB || op == MEM_SH || op == MEM_SW;
  endfunction

  function automatic bit m_misalign(input logic [3:0] op, input logic [31:0] addr);
    return (addr % op_size(op)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] addr);
    return 4'(((1 << op_size(op)) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] wdata);
    logic [31:0] r;
    int size;
    r = '0;
    size = op_size(op);
    if (m_store(op))
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % size) +: 8];
    return r;
  endfunction

  function automatic bit m_completes(input logic [3:0] op, input logic [31:0] addr,
                                     input int gnt_dly, input int rv_dly);
    return !m_misalign(op, addr) && rv_dly > 0 && (gnt_dly + 1 + rv_dly) <= TO;
  endfunction

  function automatic int m_pre(input logic [3:0] op, input logic [31:0] addr,
                               input int gnt_dly, input int rv_dly);
    if (m_misalign(op, addr)) return 1;
    if (m_completes(op, addr, gnt_dly, rv_dly)) return gnt_dly + 2 + rv_dly;
    return TO + 1;
  endfunction

  function automatic void m_commit(input logic [3:0] op, input logic [31:0] addr,
                                   input logic [31:0] rdata);
    if (m_store(op)) exp_op = MEM_NO;
    else begin
      exp_op = op; exp_addr = addr; exp_rdata = rdata;
    end
  endfunction

  // ---------------- driver: one core op plus bus responder ----------------
  task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
    bit in_resp, drop_vld, gnt_now;
    int resp_wait, post;
    obs_pre = 0; obs_stall_pre = 0; obs_stall_post = 0; obs_done = 0; obs_err = 0;
    obs_mis = 0; obs_req = 0; obs_unstable = 0; obs_be = 0; obs_addr = 0; obs_wdata = 0; obs_we = 0;
    @(posedge clk); #1;
    lsu_vld = 1'b1; lsu_op = op; lsu_addr = addr; lsu_wdata = wdata;
    in_resp = 0; drop_vld = 0; resp_wait = 0; post = 0;
    for (int c = 0; c < 64 && post < 3; c++) begin
      if (drop_vld) lsu_vld = 1'b0;
      dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = $urandom; gnt_now = 0;
      if (dbus_req) begin
        if (obs_req == 0) begin
          obs_be = dbus_be; obs_addr = dbus_addr; obs_wdata = dbus_wdata; obs_we = dbus_we;
        end else if ({dbus_be, dbus_addr, dbus_wdata, dbus_we} !== {obs_be, obs_addr, obs_wdata, obs_we})
          obs_unstable = 1;
        if (obs_req == gnt_dly) begin dbus_gnt = 1'b1; gnt_now = 1; end
        dbus_rvalid = 1'($urandom_range(0, 1));
        obs_req++;
      end else if (in_resp) begin
        resp_wait++;
        if (resp_wait == rv_dly) begin dbus_rvalid = 1'b1; dbus_rdata = rdata; in_resp = 0; end
      end else begin
        dbus_rvalid = 1'($urandom_range(0, 1));
      end
      #1;
      if (obs_done + obs_err + obs_mis == 0 && !(lsu_done || lsu_err || lsu_misalign)) begin
        obs_pre++;
        if (lsu_stall) obs_stall_pre++;
      end else begin
        if (lsu_stall) obs_stall_post++;
        post++;
      end
      if (lsu_done) obs_done++;
      if (lsu_err) obs_err++;
      if (lsu_misalign) obs_mis++;
      if (!lsu_stall) drop_vld = 1;
      @(posedge clk); #1;
      if (gnt_now) in_resp = 1;
    end
    lsu_vld = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({lsu_stall, lsu_done, lsu_err, lsu_misalign, dbus_req, dbus_we} !== 6'b0) begin
      bad++; $display("[TB] FAIL reset_ctl got=%b exp=000000", {lsu_stall, lsu_done, lsu_err, lsu_misalign, dbus_req, dbus_we});
    end
    total++;
    if ({wb_mem_op, wb_mem_addr, wb_mem_rdata, dbus_be, dbus_addr, dbus_wdata} !== '0) begin
      bad++; $display("[TB] FAIL reset_data got wb_op=%0d wb_addr=%h wb_rdata=%h be=%b exp all 0", wb_mem_op, wb_mem_addr, wb_mem_rdata, dbus_be);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    lsu_vld = 1'b1; lsu_op = MEM_NO; lsu_addr = 32'h40; #1;
    total++;
    if (lsu_stall !== 1'b0) begin bad++; $display("[TB] FAIL memno_stall got=%b exp=0", lsu_stall); end
    @(posedge clk); #1;
    total++;
    if (dbus_req !== 1'b0) begin bad++; $display("[TB] FAIL memno_req got=%b exp=0", dbus_req); end
    lsu_vld = 1'b0;
    exp_op = MEM_NO; exp_addr = 0; exp_rdata = 0;
  endtask

  task automatic test_load_word();
    run_txn(MEM_LW, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
    total++; if (obs_be !== 4'b1111) begin bad++; $display("[TB] FAIL t1_be got=%b exp=1111", obs_be); end
    total++; if (obs_we !== 1'b0) begin bad++; $display("[TB] FAIL t1_we got=%b exp=0", obs_we); end
    total++; if (obs_wdata !== 32'h0) begin bad++; $display("[TB] FAIL t1_wdata got=%h exp=0", obs_wdata); end
    total++; if (obs_done != 1) begin bad++; $display("[TB] FAIL t1_done got=%0d exp=1", obs_done); end
    total++; if (obs_pre != 3) begin bad++; $display("[TB] FAIL t1_latency got=%0d exp=3", obs_pre); end
    total++; if (obs_stall_post != 0) begin bad++; $display("[TB] FAIL t1_stall_done got=%0d exp=0", obs_stall_post); end
    total++; if (wb_mem_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL t1_wb_rdata got=%h exp=deadbeef", wb_mem_rdata); end
    total++; if (wb_mem_addr !== 32'h100) begin bad++; $display("[TB] FAIL t1_wb_addr got=%h exp=100", wb_mem_addr); end
    total++; if (wb_mem_op !== MEM_LW) begin bad++; $display("[TB] FAIL t1_wb_op got=%0d exp=%0d", wb_mem_op, MEM_LW); end
    m_commit(MEM_LW, 32'h100, 32'hDEADBEEF);
  endtask

  task automatic test_store_byte();
    run_txn(MEM_SB, 32'h203, 32'h12345678, 0, 1, 32'h0);
    total++; if (obs_addr !== 32'h200) begin bad++; $display("[TB] FAIL t2_addr got=%h exp=200", obs_addr); end
    total++; if (obs_be !== 4'b1000) begin bad++; $display("[TB] FAIL t2_be got=%b exp=1000", obs_be); end
    total++; if (obs_wdata !== 32'h78787878) begin bad++; $display("[TB] FAIL t2_wdata got=%h exp=78787878", obs_wdata); end
    total++; if (obs_we !== 1'b1) begin bad++; $display("[TB] FAIL t2_we got=%b exp=1", obs_we); end
    total++; if (obs_done != 1) begin bad++; $display("[TB] FAIL t2_done got=%0d exp=1", obs_done); end
    total++; if (wb_mem_op !== MEM_NO) begin bad++; $display("[TB] FAIL t2_wb_op got=%0d exp=0", wb_mem_op); end
    total++; if (wb_mem_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL t2_wb_rdata got=%h exp=deadbeef", wb_mem_rdata); end
    m_commit(MEM_SB, 32'h203, 32'h0);
  endtask

  task automatic test_misalign();
    run_txn(MEM_LH, 32'h101, 32'h0, 0, 1, 32'h0);
    total++; if (obs_mis != 1) begin bad++; $display("[TB] FAIL t3_misalign got=%0d exp=1", obs_mis); end
    total++; if (obs_req != 0) begin bad++; $display("[TB] FAIL t3_req got=%0d exp=0", obs_req); end
    total++; if (obs_stall_pre + obs_stall_post != 0) begin bad++; $display("[TB] FAIL t3_stall got=%0d exp=0", obs_stall_pre + obs_stall_post); end
    total++; if (obs_done != 0) begin bad++; $display("[TB] FAIL t3_done got=%0d exp=0", obs_done); end
  endtask

  task automatic test_gnt_delay();
    run_txn(MEM_SH, 32'h302, 32'h9876ABCD, 3, 1, 32'h0);
    total++; if (obs_req != 4) begin bad++; $display("[TB] FAIL t4_req_cycles got=%0d exp=4", obs_req); end
    total++; if (obs_unstable) begin bad++; $display("[TB] FAIL t4_stable got=changed exp=stable"); end
    total++; if (obs_be !== 4'b1100) begin bad++; $display("[TB] FAIL t4_be got=%b exp=1100", obs_be); end
    total++; if (obs_wdata !== 32'hABCDABCD) begin bad++; $display("[TB] FAIL t4_wdata got=%h exp=abcdabcd", obs_wdata); end
    total++; if (obs_addr !== 32'h300) begin bad++; $display("[TB] FAIL t4_addr got=%h exp=300", obs_addr); end
    total++; if (obs_stall_pre != 6 || obs_pre != 6) begin bad++; $display("[TB] FAIL t4_stall got=%0d/%0d exp=6/6", obs_stall_pre, obs_pre); end
    total++; if (obs_stall_post != 0 || obs_done != 1) begin bad++; $display("[TB] FAIL t4_done got=stall%0d done%0d exp=stall0 done1", obs_stall_post, obs_done); end
    m_commit(MEM_SH, 32'h302, 32'h0);
  endtask

  task automatic test_timeout();
    run_txn(MEM_LW, 32'h500, 32'h0, 0, -1, 32'h0);
    total++; if (obs_err != 1 || obs_done != 0) begin bad++; $display("[TB] FAIL t5_err got=err%0d done%0d exp=err1 done0", obs_err, obs_done); end
    total++; if (obs_pre != TO + 1) begin bad++; $display("[TB] FAIL t5_latency got=%0d exp=%0d", obs_pre, TO + 1); end
    total++; if ({wb_mem_op, wb_mem_addr, wb_mem_rdata} !== {exp_op, exp_addr, exp_rdata}) begin
      bad++; $display("[TB] FAIL t5_wb got=%0d/%h/%h exp=%0d/%h/%h", wb_mem_op, wb_mem_addr, wb_mem_rdata, exp_op, exp_addr, exp_rdata);
    end
    run_txn(MEM_LW, 32'h504, 32'h0, 0, 7, 32'h11112222);
    total++; if (obs_done != 1 || obs_err != 0) begin bad++; $display("[TB] FAIL t5_lastcycle got=done%0d err%0d exp=done1 err0", obs_done, obs_err); end
    m_commit(MEM_LW, 32'h504, 32'h11112222);
    run_txn(MEM_LW, 32'h508, 32'h0, 0, 8, 32'h33334444);
    total++; if (obs_err != 1 || obs_done != 0) begin bad++; $display("[TB] FAIL t5_overrun got=err%0d done%0d exp=err1 done0", obs_err, obs_done); end
    run_txn(MEM_LBU, 32'h401, 32'h0, 1, 2, 32'h55667788);
    total++; if (obs_be !== 4'b0010 || obs_done != 1) begin bad++; $display("[TB] FAIL t5_lbu got=be%b done%0d exp=be0010 done1", obs_be, obs_done); end
    m_commit(MEM_LBU, 32'h401, 32'h55667788);
    total++; if ({wb_mem_op, wb_mem_addr, wb_mem_rdata} !== {exp_op, exp_addr, exp_rdata}) begin
      bad++; $display("[TB] FAIL t5_lbu_wb got=%0d/%h/%h exp=%0d/%h/%h", wb_mem_op, wb_mem_addr, wb_mem_rdata, exp_op, exp_addr, exp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int dn;
    @(posedge clk); #1;
    lsu_vld = 1'b1; lsu_op = MEM_LW; lsu_addr = 32'h600; lsu_wdata = 32'h0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (dbus_req) begin seen = 1; dbus_gnt = 1'b1; end
    end
    total++; if (!seen) begin bad++; $display("[TB] FAIL t6_req got=0 exp=1"); end
    @(posedge clk); #1;
    dbus_gnt = 1'b0; lsu_vld = 1'b0; rst_n = 1'b0; #1;
    total++;
    if ({lsu_stall, lsu_done, lsu_err, lsu_misalign, dbus_req, dbus_we} !== 6'b0) begin
      bad++; $display("[TB] FAIL t6_ctl got=%b exp=000000", {lsu_stall, lsu_done, lsu_err, lsu_misalign, dbus_req, dbus_we});
    end
    total++;
    if ({wb_mem_op, wb_mem_addr, wb_mem_rdata, dbus_be, dbus_addr, dbus_wdata} !== '0) begin
      bad++; $display("[TB] FAIL t6_data got wb_op=%0d wb_addr=%h wb_rdata=%h exp all 0", wb_mem_op, wb_mem_addr, wb_mem_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'hCAFEF00D;
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      dbus_rvalid = 1'b0;
      if (lsu_done) dn++;
    end
    total++; if (dn != 0) begin bad++; $display("[TB] FAIL t6_done got=%0d exp=0", dn); end
    total++; if (wb_mem_rdata !== 32'h0 || lsu_stall !== 1'b0) begin
      bad++; $display("[TB] FAIL t6_after got=rdata%h stall%b exp=rdata0 stall0", wb_mem_rdata, lsu_stall);
    end
    exp_op = MEM_NO; exp_addr = 0; exp_rdata = 0;
  endtask

  task automatic test_random();
    logic [3:0] ops [8];
    logic [3:0] op;
    logic [31:0] addr, wdata, rdata;
    int gd, rv, r, e_pre, e_req;
    bit mis, comp;
    ops = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW};
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 7)];
      addr = $urandom; wdata = $urandom; rdata = $urandom;
      gd = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      rv = (r < 7) ? 1 + r % 3 : (r < 9 ? 8 : -1);
      mis = m_misalign(op, addr);
      comp = m_completes(op, addr, gd, rv);
      e_pre = m_pre(op, addr, gd, rv);
      e_req = mis ? 0 : (comp ? gd + 1 : ((gd + 1 < TO) ? gd + 1 : TO));
      run_txn(op, addr, wdata, gd, rv, rdata);
      if (comp) m_commit(op, addr, rdata);
      total++; if (obs_pre != e_pre) begin bad++; $display("[TB] FAIL rnd%0d latency got=%0d exp=%0d", i, obs_pre, e_pre); end
      total++; if (obs_stall_pre != (mis ? 0 : e_pre) || obs_stall_post != 0) begin
        bad++; $display("[TB] FAIL rnd%0d stall got=%0d/%0d exp=%0d/0", i, obs_stall_pre, obs_stall_post, mis ? 0 : e_pre);
      end
      total++; if (obs_mis != int'(mis) || obs_done != int'(comp) || obs_err != int'(!mis && !comp)) begin
        bad++; $display("[TB] FAIL rnd%0d pulses got=m%0d d%0d e%0d exp=m%0d d%0d e%0d", i, obs_mis, obs_done, obs_err, mis, comp, !mis && !comp);
      end
      total++; if (obs_req != e_req || obs_unstable) begin bad++; $display("[TB] FAIL rnd%0d req got=%0d unstable=%0d exp=%0d", i, obs_req, obs_unstable, e_req); end
      if (e_req > 0) begin
        total++;
        if ({obs_be, obs_addr, obs_wdata, obs_we} !== {m_be(op, addr), addr - addr % 4, m_wdata(op, wdata), m_store(op)}) begin
          bad++; $display("[TB] FAIL rnd%0d bus got=%b/%h/%h/%b exp=%b/%h/%h/%b", i, obs_be, obs_addr, obs_wdata, obs_we,
                          m_be(op, addr), addr - addr % 4, m_wdata(op, wdata), m_store(op));
        end
      end
      total++; if ({wb_mem_op, wb_mem_addr, wb_mem_rdata} !== {exp_op, exp_addr, exp_rdata}) begin
        bad++; $display("[TB] FAIL rnd%0d wb got=%0d/%h/%h exp=%0d/%h/%h", i, wb_mem_op, wb_mem_addr, wb_mem_rdata, exp_op, exp_addr, exp_rdata);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; lsu_vld = 1'b0; lsu_op = MEM_NO; lsu_addr = 0; lsu_wdata = 0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 0;
    exp_op = MEM_NO; exp_addr = 0; exp_rdata = 0;
    test_reset();
    test_load_word();
    test_store_byte();
    test_misalign();
    test_gnt_delay();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
